s2f_count_capture_ctrl: RTL and testbench



---
 rtl/s2f_count_capture_ctrl.sv | 172 +++++++++++++++++
 tb/tb_s2f_count_capture_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/s2f_count_capture_ctrl.sv
// s2f_count_capture_ctrl: fast-domain qualifier for a slow-domain counter bus.
// Synchronises the slow update toggle and waits a settle window. It then
// captures the counter once per update and checks +1 continuity between captures.
// Optional feature macro: S2F_GRAY_DECODE_EN. When it is defined, src_count_i
// is Gray coded and is decoded to binary before capture and check.
module s2f_count_capture_ctrl #(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned ERRCNT_W      = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                src_toggle_i,
   input  logic [WIDTH-1:0]    src_count_i,
   input  logic                capture_en_i,
   input  logic                clr_err_i,
   output logic [WIDTH-1:0]    count_out_o,
   output logic                count_valid_o,
   output logic                busy_o,
   output logic                seq_err_o,
   output logic                overrun_o,
   output logic [ERRCNT_W-1:0] err_count_o
);

   localparam int unsigned    CNT_W       = 4;
   localparam bit             NO_SETTLE   = (SETTLE_CYCLES == 0);
   localparam logic [CNT_W-1:0] SETTLE_LOAD =
      NO_SETTLE ? '0 : CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic {IDLE, SETTLE} state_t;

   state_t                  state_q;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    hist_q;
   logic [CNT_W-1:0]        settle_cnt_q;
   logic                    first_q;
   logic [WIDTH-1:0]        count_out_q;
   logic                    count_valid_q;
   logic                    busy_q;
   logic                    seq_err_q,   seq_err_d;
   logic                    overrun_q,   overrun_d;
   logic [ERRCNT_W-1:0]     err_cnt_q,   err_cnt_d;

   logic [WIDTH-1:0]        src_bin_c;
   logic [WIDTH-1:0]        expect_c;
   logic                    edge_c;
   logic                    in_settle_c;
   logic                    cap_c;
   logic                    err_c;
   logic                    ovr_c;

   // Source value as seen by capture/check logic
`ifdef S2F_GRAY_DECODE_EN
   always_comb begin
      src_bin_c = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         src_bin_c[i] = ^(src_count_i >> i);
      end
   end
`else
   assign src_bin_c = src_count_i;
`endif

   assign edge_c      = sync_q[SYNC_STAGES-1] ^ hist_q;
   assign in_settle_c = (state_q == SETTLE);
   assign expect_c    = count_out_q + WIDTH'(1);
   assign cap_c       = capture_en_i &&
                        ((!in_settle_c && edge_c && NO_SETTLE) ||
                         (in_settle_c && (settle_cnt_q == '0)));
   assign err_c       = cap_c && !first_q && (src_bin_c != expect_c);
   assign ovr_c       = in_settle_c && edge_c;

   // Toggle synchroniser and edge history; runs regardless of capture_en_i
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], src_toggle_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Capture sequencer: IDLE waits for an edge, SETTLE counts down to capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         settle_cnt_q  <= '0;
         first_q       <= 1'b1;
         count_out_q   <= '0;
         count_valid_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         count_valid_q <= cap_c;
         if (cap_c) begin
            count_out_q <= src_bin_c;
            first_q     <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (!capture_en_i) begin
                  first_q <= 1'b1;
               end else if (edge_c && !NO_SETTLE) begin
                  state_q      <= SETTLE;
                  settle_cnt_q <= SETTLE_LOAD;
                  busy_q       <= 1'b1;
               end
            end
            SETTLE: begin
               if (!capture_en_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  first_q <= 1'b1;
               end else if (settle_cnt_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  settle_cnt_q <= settle_cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky flags and saturating counter; a new event beats a same-cycle clear
   always_comb begin
      seq_err_d = seq_err_q;
      overrun_d = overrun_q;
      err_cnt_d = err_cnt_q;
      if (clr_err_i) begin
         seq_err_d = 1'b0;
         overrun_d = 1'b0;
         err_cnt_d = '0;
      end
      if (err_c) begin
         seq_err_d = 1'b1;
         if (clr_err_i)
            err_cnt_d = ERRCNT_W'(1);
         else if (err_cnt_q != '1)
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
      end
      if (ovr_c) begin
         overrun_d = 1'b1;
      end
   end

   // Error state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         seq_err_q <= 1'b0;
         overrun_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         seq_err_q <= seq_err_d;
         overrun_q <= overrun_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign count_out_o   = count_out_q;
   assign count_valid_o = count_valid_q;
   assign busy_o        = busy_q;
   assign seq_err_o     = seq_err_q;
   assign overrun_o     = overrun_q;
   assign err_count_o   = err_cnt_q;

endmodule

// File: tb/tb_s2f_count_capture_ctrl.sv
// Directed bench for s2f_count_capture_ctrl. Three instances share stimulus:
// settle 0, settle 1, and settle 4 with a 2-bit error counter.
module tb_s2f_count_capture_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       src_toggle;
   logic [3:0] src_count;
   logic       capture_en;
   logic       clr_err;

   logic [3:0] cnt0, cnt1, cnt4;
   logic       vld0, vld1, vld4;
   logic       busy0, busy1, busy4;
   logic       seq0, seq1, seq4;
   logic       ovr0, ovr1, ovr4;
   logic [7:0] err0, err1;
   logic [1:0] err4;

   int checks = 0;
   int errors = 0;
   int vcount;

   always #5 clk = ~clk;

   s2f_count_capture_ctrl #(.WIDTH(4), .SYNC_STAGES(2), .SETTLE_CYCLES(0), .ERRCNT_W(8)) dut0 (
      .clk(clk), .reset(reset), .src_toggle_i(src_toggle), .src_count_i(src_count),
      .capture_en_i(capture_en), .clr_err_i(clr_err), .count_out_o(cnt0),
      .count_valid_o(vld0), .busy_o(busy0), .seq_err_o(seq0), .overrun_o(ovr0),
      .err_count_o(err0));

   s2f_count_capture_ctrl #(.WIDTH(4), .SYNC_STAGES(2), .SETTLE_CYCLES(1), .ERRCNT_W(8)) dut1 (
      .clk(clk), .reset(reset), .src_toggle_i(src_toggle), .src_count_i(src_count),
      .capture_en_i(capture_en), .clr_err_i(clr_err), .count_out_o(cnt1),
      .count_valid_o(vld1), .busy_o(busy1), .seq_err_o(seq1), .overrun_o(ovr1),
      .err_count_o(err1));

   s2f_count_capture_ctrl #(.WIDTH(4), .SYNC_STAGES(2), .SETTLE_CYCLES(4), .ERRCNT_W(2)) dut4 (
      .clk(clk), .reset(reset), .src_toggle_i(src_toggle), .src_count_i(src_count),
      .capture_en_i(capture_en), .clr_err_i(clr_err), .count_out_o(cnt4),
      .count_valid_o(vld4), .busy_o(busy4), .seq_err_o(seq4), .overrun_o(ovr4),
      .err_count_o(err4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bus encoding the DUT expects for a binary count value
   function automatic logic [3:0] enc(input logic [3:0] v);
`ifdef S2F_GRAY_DECODE_EN
      return v ^ (v >> 1);
`else
      return v;
`endif
   endfunction

   // One slow update: drive value, flip toggle, watch 9 cycles.
   // vNk = cycle (posedges after the flip) where dutN should pulse valid, 0 = never.
   // clr_k / en_off_k / rst_k = cycle after which clr/disable/reset is driven for one edge.
   task automatic step(input logic [3:0] raw, input int v0k, input int v1k, input int v4k,
                       input int clr_k, input int en_off_k, input int rst_k,
                       input bit chk_busy);
      @(negedge clk);
      src_count  = raw;
      src_toggle = ~src_toggle;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         chk("valid0", vld0, k == v0k);
         chk("valid1", vld1, k == v1k);
         chk("valid4", vld4, k == v4k);
         if (chk_busy) begin
            chk("busy1", busy1, k == 3);
            chk("busy4", busy4, (k >= 3) && (k <= 6));
         end
         clr_err = (k == clr_k);
         reset   = (k == rst_k);
         if (k == en_off_k) capture_en = 1'b0;
      end
   endtask

   task automatic chk_out(input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e4);
      chk("count_out0", cnt0, e0);
      chk("count_out1", cnt1, e1);
      chk("count_out4", cnt4, e4);
   endtask

   task automatic chk_err(input logic e_seq, input logic [7:0] e01, input logic [1:0] e4);
      chk("seq_err0", seq0, e_seq);
      chk("seq_err1", seq1, e_seq);
      chk("seq_err4", seq4, e_seq);
      chk("err_count0", err0, e01);
      chk("err_count1", err1, e01);
      chk("err_count4", err4, e4);
   endtask

   // Disable capture for two edges (restarts the unchecked first capture) and clear errors
   task automatic prep();
      @(negedge clk);
      capture_en = 1'b0;
      clr_err    = 1'b1;
      @(negedge clk);
      clr_err    = 1'b0;
      @(negedge clk);
      capture_en = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset      = 1'b1;
      src_toggle = 1'b0;
      src_count  = 4'd0;
      capture_en = 1'b1;
      clr_err    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_out(4'd0, 4'd0, 4'd0);
      chk_err(1'b0, 8'd0, 2'd0);
      chk("rst_valid1", vld1, 1'b0);
      chk("rst_busy4", busy4, 1'b0);
      chk("rst_overrun4", ovr4, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Basic capture sequence and latency per settle depth
      step(enc(4'd0), 3, 4, 7, 0, 0, 0, 1'b1);
      chk_out(4'd0, 4'd0, 4'd0);
      step(enc(4'd1), 3, 4, 7, 0, 0, 0, 1'b1);
      chk_out(4'd1, 4'd1, 4'd1);
      step(enc(4'd2), 3, 4, 7, 0, 0, 0, 1'b1);
      chk_out(4'd2, 4'd2, 4'd2);
      chk_err(1'b0, 8'd0, 2'd0);

      // Wrap through 15 -> 0 is legal
      prep();
      step(enc(4'd14), 3, 4, 7, 0, 0, 0, 1'b0);
      step(enc(4'd15), 3, 4, 7, 0, 0, 0, 1'b0);
      chk_out(4'd15, 4'd15, 4'd15);
      step(enc(4'd0), 3, 4, 7, 0, 0, 0, 1'b0);
      chk_out(4'd0, 4'd0, 4'd0);
      step(enc(4'd1), 3, 4, 7, 0, 0, 0, 1'b0);
      chk_out(4'd1, 4'd1, 4'd1);
      chk_err(1'b0, 8'd0, 2'd0);

      // Continuity error then clear
      prep();
      step(enc(4'd3), 3, 4, 7, 0, 0, 0, 1'b0);
      step(enc(4'd4), 3, 4, 7, 0, 0, 0, 1'b0);
      chk_err(1'b0, 8'd0, 2'd0);
      step(enc(4'd7), 3, 4, 7, 0, 0, 0, 1'b0);
      chk_err(1'b1, 8'd1, 2'd1);
      @(negedge clk);
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      chk_err(1'b0, 8'd0, 2'd0);

      // Error coinciding with clear: set wins with count 1
      step(enc(4'd0), 3, 4, 7, 0, 0, 0, 1'b0);
      chk_err(1'b1, 8'd1, 2'd1);
      step(enc(4'd5), 3, 4, 7, 2, 0, 0, 1'b0);
      chk_err(1'b1, 8'd1, 2'd1);
      // Saturation of the 2-bit counter
      step(enc(4'd9), 3, 4, 7, 0, 0, 0, 1'b0);
      chk_err(1'b1, 8'd2, 2'd2);
      step(enc(4'd3), 3, 4, 7, 0, 0, 0, 1'b0);
      chk_err(1'b1, 8'd3, 2'd3);
      step(enc(4'd1), 3, 4, 7, 0, 0, 0, 1'b0);
      chk_err(1'b1, 8'd4, 2'd3);
      chk_out(4'd1, 4'd1, 4'd1);

      // Overrun: second toggle 3 clk after the first, during the long settle
      prep();
      vcount = 0;
      @(negedge clk);
      src_count  = enc(4'd2);
      src_toggle = ~src_toggle;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         chk("ovr_valid4", vld4, k == 7);
         if (vld4) vcount++;
         if (k == 3) src_toggle = ~src_toggle;
      end
      chk("ovr_pulses4", 32'(vcount), 32'd1);
      chk("overrun4", ovr4, 1'b1);
      chk("overrun1", ovr1, 1'b0);
      chk("overrun0", ovr0, 1'b0);
      chk("ovr_count_out4", cnt4, 4'd2);

      // Abort by disabling mid-settle, then unchecked first capture after re-enable
      prep();
      chk_out(4'd2, 4'd2, 4'd2);
      step(enc(4'd3), 3, 0, 0, 0, 3, 0, 1'b0);
      chk("abort_busy1", busy1, 1'b0);
      chk("abort_busy4", busy4, 1'b0);
      chk_out(4'd3, 4'd2, 4'd2);
      @(negedge clk);
      capture_en = 1'b1;
      @(negedge clk);
      step(enc(4'd9), 3, 4, 7, 0, 0, 0, 1'b0);
      chk_out(4'd9, 4'd9, 4'd9);
      chk_err(1'b0, 8'd0, 2'd0);

      // Reset one cycle before the settle-4 capture discards it
      step(enc(4'd5), 3, 4, 0, 0, 0, 5, 1'b0);
      chk_out(4'd0, 4'd0, 4'd0);
      chk("rst_busy4b", busy4, 1'b0);
      chk("rst_overrun4b", ovr4, 1'b0);

      // Raw bus 4'b0110: Gray decodes to 4, plain binary is 6
      step(4'b0110, 3, 4, 7, 0, 0, 0, 1'b0);
`ifdef S2F_GRAY_DECODE_EN
      chk_out(4'd4, 4'd4, 4'd4);
`else
      chk_out(4'd6, 4'd6, 4'd6);
`endif
      chk_err(1'b0, 8'd0, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
